serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_frame_tx.sv | 135 +++++++++++++
 tb/tb_serial_frame_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types, defaults and frame-length helper for serial_frame_tx
//
// Contents:
//   state_t          FSM state encoding (IDLE, SHIFT, PAR)
//   DATA_W_DEF       default data bits per frame
//   frame_len()      bits per frame: DATA_W, or DATA_W+1 when PARITY_BIT_EN is defined
//
// Configuration macro: PARITY_BIT_EN

package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;

    function automatic int frame_len(input int data_w);
`ifdef PARITY_BIT_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-to-serial frame transmitter, LSB first, optional even parity bit
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    parallel word to serialize (DATA_W bits)
//   in_valid   in_data valid this cycle
//   in_ready   word accepted this cycle (IDLE, or final bit of a frame)
//   ser_out    serial bit, registered
//   ser_valid  ser_out carries a frame bit, registered
//   ser_first  first bit of a frame, registered
//   ser_last   final bit of a frame, registered
//
// Configuration macro: PARITY_BIT_EN appends a parity bit (XOR of the data bits) to every frame.

module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last
);

    localparam int CW = $clog2(DATA_W + 1);
    // Counter holds the index of the data bit currently on ser_out.
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
`ifdef PARITY_BIT_EN
    localparam logic [CW-1:0] SAT_CNT = CW'(DATA_W);
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              parity, parity_n;
    logic              out_n, valid_n, first_n, last_n;
    logic              take;

    // Ready depends only on state and counter: the idle state, or the
    // final-bit cycle so the next frame can start with no gap.
`ifdef PARITY_BIT_EN
    assign in_ready = (state == IDLE) || (state == PAR);
`else
    assign in_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST_IDX));
`endif

    assign take = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            parity    <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            parity    <= parity_n;
            ser_out   <= out_n;
            ser_valid <= valid_n;
            ser_first <= first_n;
            ser_last  <= last_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        parity_n = parity;
        out_n    = 1'b0;
        valid_n  = 1'b0;
        first_n  = 1'b0;
        last_n   = 1'b0;

        if (take) begin
            // Bit 0 goes straight to the output register; the rest wait in shreg.
            state_n  = SHIFT;
            shreg_n  = in_data >> 1;
            cnt_n    = '0;
            parity_n = 1'b0;
            out_n    = in_data[0];
            valid_n  = 1'b1;
            first_n  = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == LAST_IDX) begin
`ifdef PARITY_BIT_EN
                        // parity holds the XOR of bits 0..DATA_W-2; fold in the bit on ser_out.
                        state_n  = PAR;
                        parity_n = parity ^ ser_out;
                        out_n    = parity ^ ser_out;
                        valid_n  = 1'b1;
                        last_n   = 1'b1;
                        cnt_n    = SAT_CNT;
`else
                        // Counter stays saturated at the last index until the next load.
                        state_n  = IDLE;
                        parity_n = parity ^ ser_out;
`endif
                    end else begin
                        shreg_n  = shreg >> 1;
                        out_n    = shreg[0];
                        cnt_n    = cnt + CW'(1);
                        parity_n = parity ^ ser_out;
                        valid_n  = 1'b1;
`ifndef PARITY_BIT_EN
                        last_n   = ((cnt + CW'(1)) == LAST_IDX);
`endif
                    end
                end
                PAR: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - randomized self-checking bench for serial_frame_tx (DATA_W = 8)

module tb_serial_frame_tx;

    localparam int DW = 8;
`ifdef PARITY_BIT_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_first;
    logic          ser_last;

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_tx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i of the frame for a given word, LSB first, parity last.
    function automatic logic ref_bit(input logic [DW-1:0] w, input int i);
        if (i < DW) return w[i];
        return ^w;
    endfunction

    // Called at a negedge; sends one word, then checks the whole frame and the idle cycle after it.
    // pulse_cycle (1-based) >= 1 drives in_valid with pulse_data during that frame cycle.
    task automatic run_frame(input logic [DW-1:0] w, input int pulse_cycle, input logic [DW-1:0] pulse_data);
        int ones;
        ones = 0;
        in_data  = w;
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_frame: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ser_valid, ser_out, ser_first, ser_last, in_ready} !==
                {1'b1, ref_bit(w, i), 1'(i == 0), 1'(i == FL - 1), 1'(i == FL - 1)}) begin
                n_fail++;
                $display("FAIL frame_bit w=%h i=%0d: got v/o/f/l/r=%b%b%b%b%b want 1%b%b%b%b", w, i,
                         ser_valid, ser_out, ser_first, ser_last, in_ready,
                         ref_bit(w, i), i == 0, i == FL - 1, i == FL - 1);
            end
            if (ser_out === 1'b1) ones++;
            if (i + 1 == pulse_cycle) begin
                in_valid = 1'b1;
                in_data  = pulse_data;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
`ifdef PARITY_BIT_EN
        n_checks++;
        if (ones % 2 != 0) begin
            n_fail++;
            $display("FAIL parity_detector w=%h: got %0d ones want even", w, ones);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (ser_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_frame w=%h: got valid=%b ready=%b want 0 1", w, ser_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ser_out, ser_valid, ser_first, ser_last, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_state: got o/v/f/l/r=%b%b%b%b%b want 00001",
                     ser_out, ser_valid, ser_first, ser_last, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_a5();
        run_frame(8'hA5, 0, '0);
    endtask

    task automatic test_parity_07();
        run_frame(8'h07, 0, '0);
    endtask

    task automatic test_ignore_mid_frame();
        run_frame(8'hA5, 4, 8'h3C);
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            run_frame(DW'($urandom), 0, '0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [DW-1:0] words[$];
        logic [3:0]    expq[$];
        logic [3:0]    e;
        int            idx;
        logic          hs;
        int            budget;
        words.push_back(8'hFF);
        words.push_back(8'h00);
        for (int k = 2; k < n; k++) words.push_back(DW'($urandom));
        foreach (words[k])
            for (int i = 0; i < FL; i++)
                expq.push_back({ref_bit(words[k], i), 1'(i == 0), 1'(i == FL - 1), 1'(i == FL - 1)});
        budget   = n * (FL + 2) + 10;
        idx      = 0;
        in_data  = words[0];
        in_valid = 1'b1;
        for (int c = 0; c < budget && !(idx == n && expq.size() == 0); c++) begin
            if (ser_valid === 1'b1) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_bit: got valid=1 want 0");
                end else begin
                    e = expq.pop_front();
                    if ({ser_out, ser_first, ser_last, in_ready} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_bit cyc=%0d: got o/f/l/r=%b%b%b%b want %b",
                                 c, ser_out, ser_first, ser_last, in_ready, e);
                    end
                end
            end else if (idx > 0 && expq.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_gap cyc=%0d: got valid=%b want 1", c, ser_valid);
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (idx < n) in_data = words[idx];
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!(idx == n && expq.size() == 0) || ser_valid !== 1'b0) begin
            n_fail++;
            in_valid = 1'b0;
            $display("FAIL b2b_complete: got accepted=%0d left=%0d valid=%b want %0d 0 0",
                     idx, expq.size(), ser_valid, n);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] w;
        w        = 8'hA5;
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ser_valid !== 1'b1 || ser_out !== w[i]) begin
                n_fail++;
                $display("FAIL pre_reset_bit i=%0d: got v/o=%b%b want 1%b", i, ser_valid, ser_out, w[i]);
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser_out, ser_valid, ser_first, ser_last, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL async_reset: got o/v/f/l/r=%b%b%b%b%b want 00001",
                     ser_out, ser_valid, ser_first, ser_last, in_ready);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ser_out, ser_valid, ser_first, ser_last} !== 4'b0000) begin
            n_fail++;
            $display("FAIL held_reset: got o/v/f/l=%b%b%b%b want 0000", ser_out, ser_valid, ser_first, ser_last);
        end
        rst_n = 1'b1;
        run_frame(8'h81, 0, '0);
    endtask

    initial begin
        test_reset();
        test_a5();
        test_parity_07();
        test_ignore_mid_frame();
        test_random();
        test_back_to_back(8);
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
